// File: rtl/dac_scan_gen.sv
// Triangle-wave scan generator for a DAC: ramps between signed limits with a
// programmable step and prescaler, plus hold, error and turnaround reporting.
module dac_scan_gen (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enable_i,
    input  logic               hold_i,
    input  logic signed [13:0] lo_i,
    input  logic signed [13:0] hi_i,
    input  logic        [13:0] step_i,
    input  logic        [15:0] div_i,
    output logic signed [13:0] scan_o,
    output logic               dir_o,
    output logic               turn_o,
    output logic               err_o
);

    localparam int unsigned DW = 14;
    localparam int unsigned PW = 16;
    localparam int unsigned AW = 16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_UP   = 3'd1,
        S_DOWN = 3'd2,
        S_HOLD = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic signed [DW-1:0]  r_scan;
    logic signed [DW-1:0]  w_scan_nxt;
    logic                  r_dir;
    logic                  w_dir_nxt;
    logic                  r_turn;
    logic                  w_turn_nxt;
    logic                  r_err;
    logic                  w_err_nxt;
    logic        [PW-1:0]  r_cnt;
    logic        [PW-1:0]  w_cnt_nxt;
    logic                  w_load;
    logic signed [DW-1:0]  r_lo;
    logic signed [DW-1:0]  r_hi;
    logic        [DW-1:0]  r_step;
    logic        [PW-1:0]  r_div;

    // Widened arithmetic so the ramp can never wrap before clamping.
    logic signed [AW-1:0]  w_scan_x;
    logic signed [AW-1:0]  w_step_x;
    logic signed [AW-1:0]  w_sum;
    logic signed [AW-1:0]  w_diff;
    logic                  w_tick;
    logic                  w_up_hit;
    logic                  w_dn_hit;
    logic                  w_cfg_bad;

    assign w_scan_x  = AW'(r_scan);
    assign w_step_x  = signed'(AW'(r_step));
    assign w_sum     = w_scan_x + w_step_x;
    assign w_diff    = w_scan_x - w_step_x;
    assign w_up_hit  = (w_sum >= AW'(r_hi));
    assign w_dn_hit  = (w_diff <= AW'(r_lo));
    assign w_tick    = (r_cnt == r_div);
    assign w_cfg_bad = (lo_i >= hi_i);

    assign scan_o = r_scan;
    assign dir_o  = r_dir;
    assign turn_o = r_turn;
    assign err_o  = r_err;

    // State and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_scan  <= '0;
            r_dir   <= 1'b0;
            r_turn  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_step  <= '0;
            r_div   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_scan  <= w_scan_nxt;
            r_dir   <= w_dir_nxt;
            r_turn  <= w_turn_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_load) begin
                r_lo   <= lo_i;
                r_hi   <= hi_i;
                r_step <= step_i;
                r_div  <= div_i;
            end
        end
    end

    // Next-state logic; HOLD resumes in the direction kept in r_dir.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable_i) w_state_nxt = w_cfg_bad ? S_ERR : S_UP;
            end
            S_UP: begin
                if (!enable_i)               w_state_nxt = S_IDLE;
                else if (hold_i)             w_state_nxt = S_HOLD;
                else if (w_tick && w_up_hit) w_state_nxt = S_DOWN;
            end
            S_DOWN: begin
                if (!enable_i)               w_state_nxt = S_IDLE;
                else if (hold_i)             w_state_nxt = S_HOLD;
                else if (w_tick && w_dn_hit) w_state_nxt = S_UP;
            end
            S_HOLD: begin
                if (!enable_i)   w_state_nxt = S_IDLE;
                else if (!hold_i) w_state_nxt = r_dir ? S_UP : S_DOWN;
            end
            S_ERR: begin
                if (!enable_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values for the registered outputs, prescaler and shadow load.
    always_comb begin
        w_scan_nxt = r_scan;
        w_dir_nxt  = r_dir;
        w_turn_nxt = 1'b0;
        w_err_nxt  = r_err;
        w_cnt_nxt  = r_cnt;
        w_load     = 1'b0;
        if (r_state == S_IDLE || !enable_i) begin
            w_scan_nxt = '0;
            w_dir_nxt  = 1'b0;
            w_err_nxt  = 1'b0;
            w_cnt_nxt  = '0;
            if (r_state == S_IDLE && enable_i) begin
                w_load     = 1'b1;
                w_scan_nxt = lo_i;
                w_dir_nxt  = !w_cfg_bad;
                w_err_nxt  = w_cfg_bad;
            end
        end else begin
            case (r_state)
                S_UP, S_DOWN: begin
                    if (!hold_i) begin
                        w_cnt_nxt = w_tick ? '0 : r_cnt + PW'(1);
                        if (w_tick && r_state == S_UP) begin
                            if (w_up_hit) begin
                                w_scan_nxt = r_hi;
                                w_dir_nxt  = 1'b0;
                                w_turn_nxt = 1'b1;
                            end else begin
                                w_scan_nxt = DW'(w_sum);
                            end
                        end else if (w_tick) begin
                            if (w_dn_hit) begin
                                w_scan_nxt = r_lo;
                                w_dir_nxt  = 1'b1;
                                w_turn_nxt = 1'b1;
                            end else begin
                                w_scan_nxt = DW'(w_diff);
                            end
                        end
                    end
                end
                S_ERR: begin
                    w_scan_nxt = r_lo;
                    w_err_nxt  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_scan_gen.sv
// Directed bench for dac_scan_gen: a cycle-by-cycle vector table plus
// hand-written sequences for prescaling, hold and reset-in-flight.
module tb_dac_scan_gen;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               enable_i;
    logic               hold_i;
    logic signed [13:0] lo_i;
    logic signed [13:0] hi_i;
    logic        [13:0] step_i;
    logic        [15:0] div_i;
    logic signed [13:0] scan_o;
    logic               dir_o;
    logic               turn_o;
    logic               err_o;

    int errors = 0;
    int checks = 0;

    dac_scan_gen dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enable_i (enable_i),
        .hold_i   (hold_i),
        .lo_i     (lo_i),
        .hi_i     (hi_i),
        .step_i   (step_i),
        .div_i    (div_i),
        .scan_o   (scan_o),
        .dir_o    (dir_o),
        .turn_o   (turn_o),
        .err_o    (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic        rst;
        logic        en;
        logic        hold;
        int          lo;
        int          hi;
        int          step;
        int          div;
        int          e_scan;
        logic        e_dir;
        logic        e_turn;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic rst, input logic en, input logic hold,
                       input int lo, input int hi, input int step, input int div,
                       input int e_scan, input logic e_dir, input logic e_turn, input logic e_err);
        vec_t v;
        v.name = name; v.rst = rst; v.en = en; v.hold = hold;
        v.lo = lo; v.hi = hi; v.step = step; v.div = div;
        v.e_scan = e_scan; v.e_dir = e_dir; v.e_turn = e_turn; v.e_err = e_err;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic en, input logic hold,
                         input int lo, input int hi, input int step, input int div);
        rst_i    = rst;
        enable_i = en;
        hold_i   = hold;
        lo_i     = 14'(lo);
        hi_i     = 14'(hi);
        step_i   = 14'(step);
        div_i    = 16'(div);
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input int e_scan, input logic e_dir,
                         input logic e_turn, input logic e_err);
        logic signed [13:0] exp_scan;
        exp_scan = 14'(e_scan);
        checks += 4;
        if (scan_o !== exp_scan) begin
            errors++;
            $display("FAIL %s scan_o got=%0d exp=%0d", name, scan_o, exp_scan);
        end
        if (dir_o !== e_dir) begin
            errors++;
            $display("FAIL %s dir_o got=%0b exp=%0b", name, dir_o, e_dir);
        end
        if (turn_o !== e_turn) begin
            errors++;
            $display("FAIL %s turn_o got=%0b exp=%0b", name, turn_o, e_turn);
        end
        if (err_o !== e_err) begin
            errors++;
            $display("FAIL %s err_o got=%0b exp=%0b", name, err_o, e_err);
        end
    endtask

    initial begin
        int exp_scan;
        int n_wait;
        logic turned;

        // name, rst,en,hold, lo,hi,step,div, scan,dir,turn,err
        add("reset",   1,0,0,   0,0,0,0,    0,0,0,0);
        add("idle",    0,0,0,  -4,4,2,0,    0,0,0,0);
        // Symmetric triangle with exact landing on both limits.
        add("tri_e1",  0,1,0,  -4,4,2,0,   -4,1,0,0);
        add("tri_e2",  0,1,0,  -4,4,2,0,   -2,1,0,0);
        add("tri_e3",  0,1,0,  -4,4,2,0,    0,1,0,0);
        add("tri_e4",  0,1,0,  -4,4,2,0,    2,1,0,0);
        add("tri_e5",  0,1,0,  -4,4,2,0,    4,0,1,0);
        add("tri_e6",  0,1,0,  -4,4,2,0,    2,0,0,0);
        add("tri_e7",  0,1,0,  -4,4,2,0,    0,0,0,0);
        add("tri_e8",  0,1,0,  -4,4,2,0,   -2,0,0,0);
        add("tri_e9",  0,1,0,  -4,4,2,0,   -4,1,1,0);
        add("tri_e10", 0,1,0,  -4,4,2,0,   -2,1,0,0);
        add("tri_off", 0,0,0,  -4,4,2,0,    0,0,0,0);
        // Clamping at both ends; config changes mid-scan must be ignored.
        add("clp_e1",  0,1,0,   0,5,3,0,    0,1,0,0);
        add("clp_e2",  0,1,0,   0,5,3,0,    3,1,0,0);
        add("clp_e3",  0,1,0,   0,5,3,0,    5,0,1,0);
        add("clp_e4",  0,1,0, -100,9,1,3,   2,0,0,0);
        add("clp_e5",  0,1,0, -100,9,1,3,   0,1,1,0);
        add("clp_e6",  0,1,0, -100,9,1,3,   3,1,0,0);
        add("clp_off", 0,0,0,   0,5,3,0,    0,0,0,0);
        // Zero step parks at lo with no turnaround.
        add("stp0_e1", 0,1,0,   1,3,0,0,    1,1,0,0);
        add("stp0_e2", 0,1,0,   1,3,0,0,    1,1,0,0);
        add("stp0_e3", 0,1,0,   1,3,0,0,    1,1,0,0);
        add("stp0_off",0,0,0,   1,3,0,0,    0,0,0,0);
        // lo == hi is an error; hold is ignored in ERR.
        add("err_e1",  0,1,0,   5,5,1,0,    5,0,0,1);
        add("err_e2",  0,1,1,   7,2,1,0,    5,0,0,1);
        add("err_off", 0,0,0,   5,5,1,0,    0,0,0,0);
        add("err_neg", 0,1,0,   3,-3,1,0,   3,0,0,1);
        add("err_off2",0,0,0,   3,-3,1,0,   0,0,0,0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].hold,
                  vecs[i].lo, vecs[i].hi, vecs[i].step, vecs[i].div);
            check(vecs[i].name, vecs[i].e_scan, vecs[i].e_dir, vecs[i].e_turn, vecs[i].e_err);
        end

        // Full-range limits with prescale of 3: updates on edges 4,7,10,...
        exp_scan = -8191;
        for (int e = 1; e <= 13; e++) begin
            drive(0, 1, 0, -8191, 8191, 16383, 2);
            turned = 1'b0;
            if (e >= 4 && (e - 1) % 3 == 0) begin
                exp_scan = -exp_scan;
                turned   = 1'b1;
            end
            check($sformatf("full_e%0d", e), exp_scan, exp_scan < 0, turned, 1'b0);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        check("full_off", 0, 0, 0, 0);

        // Hold at 2 while ramping up, then resume.
        drive(0, 1, 0, 0, 8, 2, 0);
        check("hold_e1", 0, 1, 0, 0);
        drive(0, 1, 0, 0, 8, 2, 0);
        check("hold_e2", 2, 1, 0, 0);
        for (int k = 0; k < 10; k++) begin
            drive(0, 1, 1, 0, 8, 2, 0);
            check($sformatf("hold_h%0d", k), 2, 1, 0, 0);
        end
        n_wait = 0;
        drive(0, 1, 0, 0, 8, 2, 0);
        while (scan_o == 14'sd2 && n_wait < 3) begin
            drive(0, 1, 0, 0, 8, 2, 0);
            n_wait++;
        end
        check("hold_release", 4, 1, 0, 0);

        // Reset mid-ramp with enable and hold asserted.
        drive(0, 1, 0, 0, 8, 2, 0);
        drive(1, 1, 1, 0, 8, 2, 0);
        check("rst_mid", 0, 0, 0, 0);
        drive(0, 1, 0, -3, 6, 3, 0);
        check("rst_restart", -3, 1, 0, 0);
        drive(0, 1, 0, -3, 6, 3, 0);
        check("rst_next", 0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout scan_o got=%0d exp=finished", scan_o);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dac_scan_gen.md
DAC_SCAN_GEN -- requirements
Module: dac_scan_gen

Interface
REQ-001 The module SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port rst_i  input  1  synchronous active-high reset.
REQ-004 Port enable_i  input  1  level; 1 = run scan, 0 = return to idle.
REQ-005 Port hold_i  input  1  level; 1 = freeze scan value and direction.
REQ-006 Port lo_i  input  14  signed two's-complement lower scan limit.
REQ-007 Port hi_i  input  14  signed two's-complement upper scan limit.
REQ-008 Port step_i  input  14  unsigned increment per update.
REQ-009 Port div_i  input  16  unsigned prescaler; one update every div_i+1 cycles.
REQ-010 Port scan_o  output  14  signed two's-complement scan value, registered; feeds the DAC output stage A channel.
REQ-011 Port dir_o  output  1  1 = ramping up, 0 = ramping down or idle.
REQ-012 Port turn_o  output  1  one-cycle pulse at each turnaround.
REQ-013 Port err_o  output  1  high while in ERR state.

Function
REQ-014 States SHALL be IDLE, UP, DOWN, HOLD, ERR; state, scan_o and all outputs registered.
REQ-015 IDLE: scan_o = 0 (mid-scale); on enable_i=1, shadow lo_r/hi_r/step_r/div_r <= inputs; if lo_i >= hi_i (signed) next state ERR, scan_o <= lo_i; else next state UP, scan_o <= lo_i, prescale counter <= 0.
REQ-016 Configuration inputs SHALL be ignored outside IDLE; changes take effect only after return to IDLE.
REQ-017 Prescale counter SHALL count 0..div_r and wrap; an update tick occurs on the cycle the counter equals div_r; div_r=0 -> tick every cycle.
REQ-018 UP on tick: sum = scan_o + step_r computed in 16-bit signed; if sum >= hi_r, scan_o <= hi_r, state DOWN, turn_o=1 next cycle; else scan_o <= sum.
REQ-019 DOWN on tick: diff = scan_o - step_r in 16-bit signed; if diff <= lo_r, scan_o <= lo_r, state UP, turn_o=1 next cycle; else scan_o <= diff.
REQ-020 Arithmetic SHALL never wrap: results outside [lo_r, hi_r] are clamped as above.
REQ-021 step_r = 0: scan_o holds at lo_r in UP, no turn_o.
REQ-022 hold_i=1 in UP/DOWN: next state HOLD, scan_o frozen, direction saved, prescale counter frozen; hold_i=0 in HOLD returns to saved direction and resumes counting.
REQ-023 ERR: scan_o = lo_r, err_o = 1; exits only via enable_i=0.
REQ-024 Priority: rst_i > enable_i=0 > hold_i=1 > tick update.
REQ-025 enable_i=0 in any non-IDLE state: next state IDLE, scan_o <= 0, dir_o <= 0, turn_o <= 0, err_o <= 0 in the same edge.
REQ-026 dir_o = 1 in UP, and in HOLD entered from UP; 0 otherwise.
REQ-027 turn_o SHALL be high for exactly one cycle per turnaround, coincident with scan_o first showing the limit value.

Reset
REQ-028 rst_i=1 SHALL force state IDLE, scan_o=0, dir_o=0, turn_o=0, err_o=0, prescale counter=0, shadow registers=0, including mid-scan.

Verification
REQ-029 lo=-4, hi=4, step=2, div=0, enable held: scan_o = -4,-2,0,2,4,2,0,-2,-4,-2...; turn_o pulses with 4 and -4; dir_o flips same cycles.
REQ-030 lo=0, hi=5, step=3, div=0: scan_o = 0,3,5(clamped),2,0(clamped),3; no value outside [0,5].
REQ-031 lo=-8191, hi=8191, step=16383, div=2: scan_o changes every 3rd cycle, alternates -8191/8191, no overflow.
REQ-032 Scan at 2 going up, hold_i=1 for 10 cycles: scan_o stays 2, dir_o=1; release -> next tick 4.
REQ-033 lo=5, hi=5 with enable: err_o=1, scan_o=5; enable_i=0 -> next cycle IDLE, scan_o=0, err_o=0.
REQ-034 rst_i=1 mid-ramp with enable_i=1 and hold_i=1: next cycle all outputs 0; after rst_i=0 restarts from lo.
